imem_arbiter: RTL and testbench

- Shares the single-port instruction memory (10-bit word address, 32-bit data, 1-cycle registered read) between two requesters.
- Requester F is the core fetch unit, read-only. Requester L is the program loader/debug port, read or write.
- Arbitrates once per cycle. At most one access is issued per cycle. Read data is routed back to the requester that issued the read.
- Sits between the Core fetch logic and the instruction_memory instance, and drives its wea/addr/din pins.

---
 rtl/imem_arbiter.sv | 96 +++++++++
 tb/tb_imem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Two-requester arbiter for the single-port instruction memory (fetch vs loader/debug).
// Loader has default priority, and a starvation counter forces a fetch grant after MAX_WAIT denied cycles.
module imem_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic          mem_wea,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;

    owner_e        owner_q, owner_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          force_f;

    always_ff @(posedge clk) begin
        if (nrst) begin
            owner_q <= OWN_NONE;
            wait_q  <= '0;
        end else begin
            owner_q <= owner_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        force_f  = (wait_q == CW'(MAX_WAIT));
        f_gnt    = 1'b0;
        l_gnt    = 1'b0;
        mem_wea  = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        owner_d  = OWN_NONE;
        wait_d   = '0;
        f_rvalid = 1'b0;
        l_rvalid = 1'b0;
        f_rdata  = '0;
        l_rdata  = '0;

        f_gnt = !nrst && f_req && (!l_req || force_f);
        l_gnt = !nrst && l_req && !f_gnt;

        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (l_gnt) begin
            mem_addr = l_addr;
            mem_wea  = l_we;
            mem_din  = l_wdata;
        end

        // Writes return nothing, so only reads claim the next-cycle response.
        if (f_gnt) begin
            owner_d = OWN_FETCH;
        end else if (l_gnt && !l_we) begin
            owner_d = OWN_LOAD;
        end

        if (f_req && !f_gnt) begin
            wait_d = force_f ? wait_q : wait_q + CW'(1);
        end

        f_rvalid = (owner_q == OWN_FETCH) && !nrst;
        l_rvalid = (owner_q == OWN_LOAD) && !nrst;
        if (f_rvalid) begin
            f_rdata = mem_dout;
        end
        if (l_rvalid) begin
            l_rdata = mem_dout;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a write-first, 1-cycle registered memory model.
module tb_imem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk;
    logic          nrst;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          l_req;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_gnt;
    logic          l_rvalid;
    logic [DW-1:0] l_rdata;
    logic          mem_wea;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_cmp;
    int n_err;

    imem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .l_req    (l_req),
        .l_we     (l_we),
        .l_addr   (l_addr),
        .l_wdata  (l_wdata),
        .l_gnt    (l_gnt),
        .l_rvalid (l_rvalid),
        .l_rdata  (l_rdata),
        .mem_wea  (mem_wea),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wea) mem[mem_addr] <= mem_din;
        mem_dout <= mem_wea ? mem_din : mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        f_req = 1'b0; f_addr = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    endtask

    task automatic lwrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc();
        idle_inputs();
        l_req = 1'b1; l_we = 1'b1; l_addr = a; l_wdata = d;
        settle();
        chk("preload_l_gnt", {31'd0, l_gnt}, 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        nrst  = 1'b1;
        idle_inputs();

        // Requests during reset must not be granted.
        cyc();
        f_req = 1'b1; f_addr = 10'd7; l_req = 1'b1; l_we = 1'b1; l_addr = 10'd9; l_wdata = 32'hFFFF_FFFF;
        settle();
        chk("rst_f_gnt", {31'd0, f_gnt}, 32'd0);
        chk("rst_l_gnt", {31'd0, l_gnt}, 32'd0);
        chk("rst_mem_wea", {31'd0, mem_wea}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        chk("rst_rvalid", {30'd0, f_rvalid, l_rvalid}, 32'd0);

        cyc();
        nrst = 1'b0;
        idle_inputs();
        lwrite(10'd5, 32'hDEAD_BEEF);
        lwrite(10'd1, 32'h1111_1111);
        lwrite(10'd2, 32'h2222_2222);

        // Fetch only
        cyc();
        idle_inputs();
        f_req = 1'b1; f_addr = 10'd5;
        settle();
        chk("fo_f_gnt", {31'd0, f_gnt}, 32'd1);
        chk("fo_l_gnt", {31'd0, l_gnt}, 32'd0);
        chk("fo_mem_wea", {31'd0, mem_wea}, 32'd0);
        chk("fo_mem_addr", {22'd0, mem_addr}, 32'd5);
        chk("fo_mem_din", mem_din, 32'd0);
        cyc();
        idle_inputs();
        settle();
        chk("fo_f_rvalid", {31'd0, f_rvalid}, 32'd1);
        chk("fo_f_rdata", f_rdata, 32'hDEAD_BEEF);
        chk("fo_l_rvalid", {31'd0, l_rvalid}, 32'd0);
        chk("fo_l_rdata", l_rdata, 32'd0);

        // Loader write, then fetch reads the same address next cycle
        cyc();
        idle_inputs();
        l_req = 1'b1; l_we = 1'b1; l_addr = 10'h3FF; l_wdata = 32'h1234_5678;
        settle();
        chk("wr_l_gnt", {31'd0, l_gnt}, 32'd1);
        chk("wr_mem_wea", {31'd0, mem_wea}, 32'd1);
        chk("wr_mem_addr", {22'd0, mem_addr}, 32'h3FF);
        chk("wr_mem_din", mem_din, 32'h1234_5678);
        cyc();
        idle_inputs();
        f_req = 1'b1; f_addr = 10'h3FF;
        settle();
        chk("raw_f_gnt", {31'd0, f_gnt}, 32'd1);
        chk("raw_mem_wea", {31'd0, mem_wea}, 32'd0);
        chk("raw_no_rvalid_after_wr", {30'd0, f_rvalid, l_rvalid}, 32'd0);
        cyc();
        idle_inputs();
        settle();
        chk("raw_f_rvalid", {31'd0, f_rvalid}, 32'd1);
        chk("raw_f_rdata", f_rdata, 32'h1234_5678);
        chk("raw_l_rvalid", {31'd0, l_rvalid}, 32'd0);

        // Starvation: both requesting reads; fetch forced through at cycles 4 and 9
        for (int c = 0; c < 10; c++) begin
            cyc();
            idle_inputs();
            f_req = 1'b1; f_addr = 10'd1;
            l_req = 1'b1; l_we = 1'b0; l_addr = 10'd2;
            settle();
            chk("st_f_gnt", {31'd0, f_gnt}, (c == 4 || c == 9) ? 32'd1 : 32'd0);
            chk("st_l_gnt", {31'd0, l_gnt}, (c == 4 || c == 9) ? 32'd0 : 32'd1);
            chk("st_mem_addr", {22'd0, mem_addr}, (c == 4 || c == 9) ? 32'd1 : 32'd2);
            if (c > 0) begin
                chk("st_f_rvalid", {31'd0, f_rvalid}, (c == 5) ? 32'd1 : 32'd0);
                chk("st_l_rvalid", {31'd0, l_rvalid}, (c == 5) ? 32'd0 : 32'd1);
                chk("st_rdata", (c == 5) ? f_rdata : l_rdata, (c == 5) ? 32'h1111_1111 : 32'h2222_2222);
            end
        end
        cyc();
        idle_inputs();
        settle();
        chk("st_tail_f_rvalid", {31'd0, f_rvalid}, 32'd1);
        chk("st_tail_f_rdata", f_rdata, 32'h1111_1111);

        // Dropping fetch request clears the wait count
        for (int c = 0; c < 8; c++) begin
            cyc();
            idle_inputs();
            f_req = (c != 2); f_addr = 10'd1;
            l_req = 1'b1; l_we = 1'b0; l_addr = 10'd2;
            settle();
            chk("drop_f_gnt", {31'd0, f_gnt}, (c == 7) ? 32'd1 : 32'd0);
        end

        // Pipelined mixed reads
        cyc();
        idle_inputs();
        f_req = 1'b1; f_addr = 10'd1;
        settle();
        chk("pm_f_gnt", {31'd0, f_gnt}, 32'd1);
        cyc();
        idle_inputs();
        l_req = 1'b1; l_we = 1'b0; l_addr = 10'd2;
        settle();
        chk("pm_l_gnt", {31'd0, l_gnt}, 32'd1);
        chk("pm_c1_rv", {30'd0, f_rvalid, l_rvalid}, 32'd2);
        chk("pm_c1_f_rdata", f_rdata, 32'h1111_1111);
        cyc();
        idle_inputs();
        settle();
        chk("pm_c2_rv", {30'd0, f_rvalid, l_rvalid}, 32'd1);
        chk("pm_c2_l_rdata", l_rdata, 32'h2222_2222);
        chk("pm_c2_f_rdata", f_rdata, 32'd0);

        // Reset mid-read
        cyc();
        idle_inputs();
        f_req = 1'b1; f_addr = 10'd5;
        settle();
        chk("rm_f_gnt_t", {31'd0, f_gnt}, 32'd1);
        cyc();
        nrst = 1'b1;
        settle();
        chk("rm_f_rvalid_t1", {31'd0, f_rvalid}, 32'd0);
        chk("rm_f_rdata_t1", f_rdata, 32'd0);
        chk("rm_gnt_t1", {30'd0, f_gnt, l_gnt}, 32'd0);
        chk("rm_mem_addr_t1", {22'd0, mem_addr}, 32'd0);
        cyc();
        nrst = 1'b0;
        settle();
        chk("rm_f_gnt_t2", {31'd0, f_gnt}, 32'd1);
        chk("rm_f_rvalid_t2", {31'd0, f_rvalid}, 32'd0);
        cyc();
        idle_inputs();
        settle();
        chk("rm_f_rvalid_t3", {31'd0, f_rvalid}, 32'd1);
        chk("rm_f_rdata_t3", f_rdata, 32'hDEAD_BEEF);

        // Idle
        for (int c = 0; c < 10; c++) begin
            cyc();
            idle_inputs();
            settle();
            chk("idle_mem", {9'd0, mem_wea, mem_addr, 12'd0}, 32'd0);
            chk("idle_gnt_rv", {28'd0, f_gnt, l_gnt, f_rvalid, l_rvalid}, 32'd0);
        end
        cyc();
        f_req = 1'b1; f_addr = 10'd1; l_req = 1'b1; l_we = 1'b0; l_addr = 10'd2;
        settle();
        chk("idle_wait_zero_l_gnt", {30'd0, f_gnt, l_gnt}, 32'd1);
        cyc();
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
